tl_fifo_drain_arbiter: RTL

//  Read-side controller for the transaction-layer class FIFOs.
//  - Drains NUM_SRC source FIFOs (pop/empty side) into one destination FIFO (push/almost_full side).
//  - Selects sources with a round-robin arbiter.
//  - Accounts for the FIFO's 1-cycle registered read data and its lagging occupancy flags.

---
 rtl/tl_fifo_drain_arbiter_pkg.sv | 14 +
 rtl/tl_fifo_drain_arbiter_rr.sv | 25 ++
 rtl/tl_fifo_drain_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tl_fifo_drain_arbiter_pkg.sv
// rtl/tl_fifo_drain_arbiter_pkg.sv - shared constants and FSM encoding for the FIFO drain arbiter
package tl_fifo_drain_arbiter_pkg;

  localparam int NUM_SRC          = 4;
  localparam int DEF_LINE_SIZE    = 12;
  localparam int DEF_HOLDOFF      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/tl_fifo_drain_arbiter_rr.sv
// rtl/tl_fifo_drain_arbiter_rr.sv - 4-way combinational round-robin arbiter
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] cand;

  // First requester found scanning ptr, ptr+1, ... with natural 2-bit wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/tl_fifo_drain_arbiter.sv
// rtl/tl_fifo_drain_arbiter.sv - drains four source FIFOs into one destination FIFO
module tl_fifo_drain_arbiter
  import tl_fifo_drain_arbiter_pkg::*;
#(
  parameter int LINE_SIZE = DEF_LINE_SIZE,
  parameter int HOLDOFF   = DEF_HOLDOFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NUM_SRC-1:0]           src_empty,
  input  logic [NUM_SRC*LINE_SIZE-1:0] src_data,
  input  logic                         dst_afull,
  output logic [NUM_SRC-1:0]           src_pop,
  output logic                         dst_push,
  output logic [LINE_SIZE-1:0]         dst_data,
  output logic [1:0]                   last_src,
  output logic                         idle
);

  localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  state_e                state_q, state_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]     hold_cnt_q [NUM_SRC];
  logic [HOLD_W-1:0]     hold_cnt_d [NUM_SRC];
  logic                  s0_valid_q, s0_valid_d;
  logic [1:0]            s0_idx_q, s0_idx_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [1:0]            s1_idx_q, s1_idx_d;
  logic [NUM_SRC-1:0]    src_pop_q, src_pop_d;
  logic                  dst_push_q, dst_push_d;
  logic [LINE_SIZE-1:0]  dst_data_q, dst_data_d;
  logic [1:0]            last_src_q, last_src_d;
  logic                  idle_q, idle_d;

  logic [NUM_SRC-1:0]    eligible;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic                  issue;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible[i] = !src_empty[i] && (hold_cnt_q[i] == '0);
    end
  end

  rr_arbiter4 u_arb (
    .req         (eligible),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_pop_d  = '0;
    dst_data_d = dst_data_q;
    last_src_d = last_src_q;

    // Dropping en in ACTIVE must suppress the issue on that same edge.
    issue = (state_q == ST_ACTIVE) && en && !dst_afull && grant_valid;

    for (int i = 0; i < NUM_SRC; i++) begin
      hold_cnt_d[i] = (hold_cnt_q[i] != '0) ? hold_cnt_q[i] - HOLD_W'(1) : '0;
    end

    if (issue) begin
      src_pop_d[grant_idx]  = 1'b1;
      rr_ptr_d              = grant_idx + 2'd1;
      hold_cnt_d[grant_idx] = HOLD_W'(HOLDOFF);
    end

    s0_valid_d = issue;
    s0_idx_d   = issue ? grant_idx : s0_idx_q;
    s1_valid_d = s0_valid_q;
    s1_idx_d   = s0_idx_q;

    // Stage 1 lines up with the FIFO's registered data_out, so capture it now.
    dst_push_d = s1_valid_q;
    if (s1_valid_q) begin
      dst_data_d = src_data[int'(s1_idx_q) * LINE_SIZE +: LINE_SIZE];
      last_src_d = s1_idx_q;
    end

    case (state_q)
      ST_IDLE:   if (en) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)                             state_d = ST_ACTIVE;
        else if (!s0_valid_q && !s1_valid_q) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      for (int i = 0; i < NUM_SRC; i++) hold_cnt_q[i] <= '0;
      s0_valid_q <= 1'b0;
      s0_idx_q   <= 2'd0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= 2'd0;
      src_pop_q  <= '0;
      dst_push_q <= 1'b0;
      dst_data_q <= '0;
      last_src_q <= 2'd0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      for (int i = 0; i < NUM_SRC; i++) hold_cnt_q[i] <= hold_cnt_d[i];
      s0_valid_q <= s0_valid_d;
      s0_idx_q   <= s0_idx_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      src_pop_q  <= src_pop_d;
      dst_push_q <= dst_push_d;
      dst_data_q <= dst_data_d;
      last_src_q <= last_src_d;
      idle_q     <= idle_d;
    end
  end

  assign src_pop  = src_pop_q;
  assign dst_push = dst_push_q;
  assign dst_data = dst_data_q;
  assign last_src = last_src_q;
  assign idle     = idle_q;

endmodule
